// File: rtl/spart_receiver.sv
// SPART serial receiver: 1 start bit + 8 data bits LSB-first, sampled on the baud tick.
// Define SPART_RX_SYNC_EN to insert a 2-flop synchronizer on RxD (adds 2 cycles of latency).
module spart_receiver (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       baud_rate_generator,
  output logic [7:0] receiver_buffer,
  output logic       RDA
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    DATA      = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t     state, next_state;
  logic       rx_s;
  logic [3:0] bit_cnt;
  logic [6:0] shift_reg;
  logic       start_clr, shift_en, load_byte, clr_rda;

`ifdef SPART_RX_SYNC_EN
  logic sync_q1, sync_q2;

  // Flops reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= RxD;
      sync_q2 <= sync_q1;
    end
  end

  assign rx_s = sync_q2;
`else
  assign rx_s = RxD;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, otherwise latches are inferred.
  always_comb begin
    next_state = state;
    start_clr  = 1'b0;
    shift_en   = 1'b0;
    load_byte  = 1'b0;
    clr_rda    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          next_state = START;
          clr_rda    = 1'b1;
        end
      end
      START: begin
        if (baud_rate_generator) begin
          next_state = DATA;
          start_clr  = 1'b1;
        end
      end
      DATA: begin
        if (baud_rate_generator) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd7) begin
            load_byte  = 1'b1;
            next_state = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A 0 in data bit 7 must not be mistaken for the next start bit.
        if (rx_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Seven bits suffice: bit 7 goes straight from the line into the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= 4'd0;
      shift_reg <= 7'd0;
    end else if (start_clr) begin
      bit_cnt   <= 4'd0;
      shift_reg <= 7'd0;
    end else if (shift_en) begin
      bit_cnt   <= bit_cnt + 4'd1;
      shift_reg <= {rx_s, shift_reg[6:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      receiver_buffer <= 8'h00;
      RDA             <= 1'b0;
    end else if (load_byte) begin
      receiver_buffer <= {rx_s, shift_reg};
      RDA             <= 1'b1;
    end else if (clr_rda) begin
      RDA <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_receiver.sv
// Directed testbench for spart_receiver: frames, bit-7-low hold, back-to-back bytes, mid-frame reset.
module tb_spart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic       baud_rate_generator;
  logic [7:0] receiver_buffer;
  logic       RDA;

  int checks   = 0;
  int failures = 0;

  spart_receiver dut (
    .clk                 (clk),
    .reset               (reset),
    .RxD                 (RxD),
    .baud_rate_generator (baud_rate_generator),
    .receiver_buffer     (receiver_buffer),
    .RDA                 (RDA)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One-cycle tick straddling a single rising edge.
  task automatic pulse_tick();
    @(negedge clk) baud_rate_generator = 1'b1;
    @(negedge clk) baud_rate_generator = 1'b0;
  endtask

  // Sends start + 8 data bits, checking RDA low throughout and the byte right after the last tick.
  // RxD is left at data bit 7; the caller decides when the line returns high.
  task automatic send_byte(input logic [7:0] b);
    RxD = 1'b0;
    repeat (9) @(negedge clk);
    check("rda_after_start", {7'd0, RDA}, 8'h00);
    pulse_tick();
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (8) @(negedge clk);
      pulse_tick();
      if (i < 7) check($sformatf("rda_bit%0d", i), {7'd0, RDA}, 8'h00);
    end
    check("buffer_byte", receiver_buffer, b);
    check("rda_byte", {7'd0, RDA}, 8'h01);
  endtask

  logic [7:0] frames [22] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3,
                              8'h7E, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                              8'hDE, 8'hF0, 8'h0F, 8'hE7, 8'h18, 8'h66};

  initial begin
    reset               = 1'b0;
    RxD                 = 1'b1;
    baud_rate_generator = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rda", {7'd0, RDA}, 8'h00);
    check("reset_buffer", receiver_buffer, 8'h00);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_rda", {7'd0, RDA}, 8'h00);
    check("idle_buffer", receiver_buffer, 8'h00);

    // Basic frame.
    send_byte(8'hA5);
    RxD = 1'b1;
    repeat (20) @(negedge clk);
    check("a5_hold_buffer", receiver_buffer, 8'hA5);
    check("a5_hold_rda", {7'd0, RDA}, 8'h01);

    // Bit 7 low: the receiver must wait for the line to go high before re-arming.
    send_byte(8'h80);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wait_high_rda", {7'd0, RDA}, 8'h01);
      check("wait_high_buffer", receiver_buffer, 8'h80);
    end
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    check("rda_through_idle", {7'd0, RDA}, 8'h01);
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    check("rda_cleared_by_start", {7'd0, RDA}, 8'h00);
    check("buffer_kept_on_start", receiver_buffer, 8'h80);
    send_byte(8'h5A);
    RxD = 1'b1;
    repeat (20) @(negedge clk);

    // Back-to-back frames.
    foreach (frames[k]) begin
      send_byte(frames[k]);
      RxD = 1'b1;
      repeat (20) @(negedge clk);
    end

    // Reset in the middle of a frame: partial byte must not appear.
    RxD = 1'b0;
    repeat (9) @(negedge clk);
    pulse_tick();
    for (int i = 0; i < 4; i++) begin
      RxD = i[0];
      repeat (8) @(negedge clk);
      pulse_tick();
    end
    reset = 1'b0;
    #1;
    check("abort_rda", {7'd0, RDA}, 8'h00);
    check("abort_buffer", receiver_buffer, 8'h00);
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_abort_buffer", receiver_buffer, 8'h00);
    send_byte(8'h3C);
    RxD = 1'b1;
    repeat (20) @(negedge clk);

    // Ticks while idle change nothing.
    for (int i = 0; i < 5; i++) begin
      repeat (3) @(negedge clk);
      pulse_tick();
      check("idle_tick_rda", {7'd0, RDA}, 8'h01);
      check("idle_tick_buffer", receiver_buffer, 8'h3C);
    end
    send_byte(8'hC6);
    RxD = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
